exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_pkg.sv | 15 +
 rtl/exc_ctrl_if.sv | 30 +++
 rtl/exc_ctrl.sv | 105 ++++++++++
 tb/tb_exc_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/trap controller.
package exc_pkg;

  localparam int unsigned PcW = 16;
  localparam logic [PcW-1:0] TrapVecDefault = 16'h0002;

  typedef enum logic [2:0] {
    StRun,
    StHandler,
    StRedirT,
    StRedirR,
    StHalted
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// Decode-stage event flags in, fetch redirect and status out.
interface exc_ctrl_if;
  import exc_pkg::*;

  logic           valid;
  logic           stall;
  logic           siic;
  logic           rti;
  logic           err;
  logic           halt;
  logic [PcW-1:0] pc_plus2;
  logic           redirect;
  logic [PcW-1:0] redirect_pc;
  logic           flush;
  logic [PcW-1:0] epc;
  logic           in_handler;
  logic           halt_out;
  logic           fault;

  modport master (
    output valid, stall, siic, rti, err, halt, pc_plus2,
    input  redirect, redirect_pc, flush, epc, in_handler, halt_out, fault
  );

  modport slave (
    input  valid, stall, siic, rti, err, halt, pc_plus2,
    output redirect, redirect_pc, flush, epc, in_handler, halt_out, fault
  );

endinterface

// File: rtl/exc_ctrl.sv
// Single-level trap/return controller with sticky halt and fault flags.
// Define EXC_ILLEGAL_TRAP_EN to turn an illegal opcode in RUN into a trap.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [PcW-1:0] TRAP_VEC = TrapVecDefault
) (
  input logic       clk,
  input logic       rst_n,
  exc_ctrl_if.slave bus
);

  exc_state_e     state_q, state_d;
  logic [PcW-1:0] epc_q, epc_d;
  logic           fault_q, fault_d;
  logic           halt_q, halt_d;
  logic           accept;

  assign accept = bus.valid && !bus.stall && (state_q == StRun || state_q == StHandler);

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    fault_d = fault_q;
    halt_d  = halt_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (bus.halt) begin
            halt_d  = 1'b1;
            state_d = StHalted;
          end else if (bus.err) begin
            fault_d = 1'b1;
`ifdef EXC_ILLEGAL_TRAP_EN
            epc_d   = bus.pc_plus2;
            state_d = StRedirT;
`else
            state_d = StHalted;
`endif
          end else if (bus.siic) begin
            epc_d   = bus.pc_plus2;
            state_d = StRedirT;
          end else if (bus.rti) begin
            fault_d = 1'b1;
            state_d = StHalted;
          end
        end
      end
      StHandler: begin
        if (accept) begin
          if (bus.halt) begin
            halt_d  = 1'b1;
            state_d = StHalted;
          end else if (bus.err || bus.siic) begin
            // No nesting: epc keeps the outer return address.
            fault_d = 1'b1;
            state_d = StHalted;
          end else if (bus.rti) begin
            state_d = StRedirR;
          end
        end
      end
      StRedirT: state_d = StHandler;
      StRedirR: state_d = StRun;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      epc_q   <= '0;
      fault_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
      halt_q  <= halt_d;
    end
  end

  // Outputs decode the registered state only, so reset clears them at once.
  always_comb begin
    bus.redirect    = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;
    if (state_q == StRedirT) begin
      bus.redirect    = 1'b1;
      bus.flush       = 1'b1;
      bus.redirect_pc = TRAP_VEC;
    end else if (state_q == StRedirR) begin
      bus.redirect    = 1'b1;
      bus.flush       = 1'b1;
      bus.redirect_pc = epc_q;
    end
  end

  assign bus.epc        = epc_q;
  assign bus.in_handler = (state_q == StHandler);
  assign bus.halt_out   = halt_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected outputs, a monitor compares them.
module tb_exc_ctrl;

  logic clk;
  logic rst_n;
  int   pcyc;
  int   n_checks;
  int   n_fail;
  event chk_ev;

  typedef struct {
    string       name;
    int          due;
    logic [36:0] v;
  } exp_t;

  exp_t sb[$];

  exc_ctrl_if bus ();

  exc_ctrl #(.TRAP_VEC(16'h0002)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic logic [36:0] pk(input logic r, input logic [15:0] rpc, input logic fl,
                                     input logic [15:0] e, input logic ih, input logic ho,
                                     input logic fa);
    return {r, rpc, fl, e, ih, ho, fa};
  endfunction

  // Monitor: pops every expectation that has come due and compares it with the DUT.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0 && sb[0].due <= pcyc) begin
        exp_t        e;
        logic [36:0] act;
        e   = sb.pop_front();
        act = pk(bus.redirect, bus.redirect_pc, bus.flush, bus.epc, bus.in_handler,
                 bus.halt_out, bus.fault);
        n_checks++;
        if (e.due != pcyc || act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got redir=%b rpc=%h flush=%b epc=%h ih=%b halt=%b fault=%b, want redir=%b rpc=%h flush=%b epc=%h ih=%b halt=%b fault=%b (due %0d now %0d)",
                   e.name, act[36], act[35:20], act[19], act[18:3], act[2], act[1], act[0],
                   e.v[36], e.v[35:20], e.v[19], e.v[18:3], e.v[2], e.v[1], e.v[0],
                   e.due, pcyc);
        end
      end
    end
  end

  task automatic push(input string n, input int due, input logic r, input logic [15:0] rpc,
                      input logic fl, input logic [15:0] e, input logic ih, input logic ho,
                      input logic fa);
    exp_t x;
    x.name = n;
    x.due  = due;
    x.v    = pk(r, rpc, fl, e, ih, ho, fa);
    sb.push_back(x);
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic exp_next(input string n, input logic r, input logic [15:0] rpc,
                          input logic fl, input logic [15:0] e, input logic ih,
                          input logic ho, input logic fa);
    push(n, pcyc + 1, r, rpc, fl, e, ih, ho, fa);
  endtask

  // Expectation checked immediately, between clock edges.
  task automatic exp_now(input string n, input logic r, input logic [15:0] rpc,
                         input logic fl, input logic [15:0] e, input logic ih,
                         input logic ho, input logic fa);
    push(n, pcyc, r, rpc, fl, e, ih, ho, fa);
    ->chk_ev;
  endtask

  task automatic set_in(input logic v, input logic st, input logic si, input logic rt,
                        input logic er, input logic ha, input logic [15:0] pc);
    bus.valid    = v;
    bus.stall    = st;
    bus.siic     = si;
    bus.rti      = rt;
    bus.err      = er;
    bus.halt     = ha;
    bus.pc_plus2 = pc;
  endtask

  // One decode cycle: inputs applied just after an edge, sampled on the next one.
  task automatic drv(input logic v, input logic st, input logic si, input logic rt,
                     input logic er, input logic ha, input logic [15:0] pc);
    @(posedge clk);
    #1;
    set_in(v, st, si, rt, er, ha, pc);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    #2;
    exp_now("reset_hold", 0, 16'h0, 0, 16'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle();                                        exp_next("reset_idle",    0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 16'h0040);               exp_next("bubble_siic",   0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 16'h0040);               exp_next("trap_redir",    1, 16'h0002, 1, 16'h0040, 0, 0, 0);
    idle();                                        exp_next("enter_handler", 0, 16'h0000, 0, 16'h0040, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 16'h0004);               exp_next("handler_nop",   0, 16'h0000, 0, 16'h0040, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 16'h0006);               exp_next("rti_redir",     1, 16'h0040, 1, 16'h0040, 0, 0, 0);
    idle();                                        exp_next("back_run",      0, 16'h0000, 0, 16'h0040, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 1, 0, 0, 0, 16'h0080);             exp_next("stall_siic",    0, 16'h0000, 0, 16'h0040, 0, 0, 0);
    end
    drv(1, 0, 1, 0, 0, 0, 16'h0080);               exp_next("unstall_trap",  1, 16'h0002, 1, 16'h0080, 0, 0, 0);
    idle();                                        exp_next("handler2",      0, 16'h0000, 0, 16'h0080, 1, 0, 0);
    drv(1, 1, 0, 1, 0, 0, 16'h0000);               exp_next("stall_rti",     0, 16'h0000, 0, 16'h0080, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 16'h0000);               exp_next("rti2_redir",    1, 16'h0080, 1, 16'h0080, 0, 0, 0);
    idle();                                        exp_next("back_run2",     0, 16'h0000, 0, 16'h0080, 0, 0, 0);

    drv(1, 0, 1, 0, 0, 0, 16'hFFFE);               exp_next("fffe_trap",     1, 16'h0002, 1, 16'hFFFE, 0, 0, 0);
    idle();                                        exp_next("fffe_handler",  0, 16'h0000, 0, 16'hFFFE, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 16'h0000);               exp_next("fffe_return",   1, 16'hFFFE, 1, 16'hFFFE, 0, 0, 0);
    idle();                                        exp_next("fffe_run",      0, 16'h0000, 0, 16'hFFFE, 0, 0, 0);

    drv(1, 0, 1, 0, 0, 0, 16'h0060);               exp_next("nest_trap",     1, 16'h0002, 1, 16'h0060, 0, 0, 0);
    idle();                                        exp_next("nest_handler",  0, 16'h0000, 0, 16'h0060, 1, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 16'h0070);               exp_next("siic_nest",     0, 16'h0000, 0, 16'h0060, 0, 0, 1);
    idle();                                        exp_next("nest_halted",   0, 16'h0000, 0, 16'h0060, 0, 0, 1);

    do_reset();
    idle();                                        exp_next("reset2_idle",   0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 16'h0010);               exp_next("rti_in_run",    0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    drv(1, 0, 1, 0, 0, 0, 16'h0030);               exp_next("halted_siic",   0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 1, 16'h0030);               exp_next("halted_halt",   0, 16'h0000, 0, 16'h0000, 0, 0, 1);

    do_reset();
    drv(1, 0, 1, 0, 0, 1, 16'h0050);               exp_next("halt_prio",     0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    idle();                                        exp_next("halt_sticky",   0, 16'h0000, 0, 16'h0000, 0, 1, 0);

    do_reset();
`ifdef EXC_ILLEGAL_TRAP_EN
    drv(1, 0, 0, 0, 1, 0, 16'h0100);               exp_next("err_trap",      1, 16'h0002, 1, 16'h0100, 0, 0, 1);
    idle();                                        exp_next("err_handler",   0, 16'h0000, 0, 16'h0100, 1, 0, 1);
`else
    drv(1, 0, 0, 0, 1, 0, 16'h0100);               exp_next("err_halt",      0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    idle();                                        exp_next("err_halted",    0, 16'h0000, 0, 16'h0000, 0, 0, 1);
`endif

    do_reset();
    drv(1, 0, 1, 0, 0, 0, 16'h0200);               exp_next("pre_rst_trap",  1, 16'h0002, 1, 16'h0200, 0, 0, 0);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_now("rst_mid_redir", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();                                        exp_next("post_rst_run",  0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    idle();                                        exp_next("no_redir_pulse", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
